// File: rtl/reg_file_arbiter_if.sv
// reg_file_arbiter_if: requester ports A/B plus the register-file side of the arbiter.
interface reg_file_arbiter_if;
  logic       a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [3:0] a_reg;
  logic [7:0] a_wdata, a_rdata;
  logic       b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [3:0] b_reg;
  logic [7:0] b_wdata, b_rdata;
  logic [3:0] rf_reg_in;
  logic [7:0] rf_data_in, rf_data_out;
  logic       rf_write_ctrl;
  modport master (
    output a_req, a_we, a_lock, a_reg, a_wdata,
    output b_req, b_we, b_lock, b_reg, b_wdata,
    output rf_data_out,
    input  a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
    input  rf_reg_in, rf_data_in, rf_write_ctrl
  );
  modport slave (
    input  a_req, a_we, a_lock, a_reg, a_wdata,
    input  b_req, b_we, b_lock, b_reg, b_wdata,
    input  rf_data_out,
    output a_gnt, a_rdata, a_rvalid, b_gnt, b_rdata, b_rvalid,
    output rf_reg_in, rf_data_in, rf_write_ctrl
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin arbiter with bounded burst lock sharing a 16x8 register file.
module reg_file_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic              CLK,
  input logic              RESET,
  reg_file_arbiter_if.slave bus
);
  logic       r_last, r_lock_valid, r_lock_owner, r_a_rvalid, r_b_rvalid;
  logic [3:0] r_burst_cnt;
  logic [7:0] r_a_rdata, r_b_rdata;
  logic       w_a_hold, w_b_hold, w_gnt_a, w_gnt_b, w_any, w_lock, w_owner_req;
  // A lock holds the port until the burst is spent while the other side waits.
  always_comb begin
    w_a_hold    = r_lock_valid && !r_lock_owner && bus.a_req && (!bus.b_req || r_burst_cnt < 4'(MAX_BURST));
    w_b_hold    = r_lock_valid &&  r_lock_owner && bus.b_req && (!bus.a_req || r_burst_cnt < 4'(MAX_BURST));
    w_gnt_a     = !RESET && (w_a_hold || (!w_b_hold && bus.a_req && (!bus.b_req ||  r_last)));
    w_gnt_b     = !RESET && (w_b_hold || (!w_a_hold && bus.b_req && (!bus.a_req || !r_last)));
    w_any       = w_gnt_a || w_gnt_b;
    w_lock      = w_gnt_b ? bus.b_lock : bus.a_lock;
    w_owner_req = r_lock_owner ? bus.b_req : bus.a_req;
  end
  assign bus.a_gnt         = w_gnt_a;
  assign bus.b_gnt         = w_gnt_b;
  assign bus.a_rdata       = r_a_rdata;
  assign bus.b_rdata       = r_b_rdata;
  assign bus.a_rvalid      = r_a_rvalid;
  assign bus.b_rvalid      = r_b_rvalid;
  assign bus.rf_reg_in     = w_gnt_a ? bus.a_reg   : w_gnt_b ? bus.b_reg   : '0;
  assign bus.rf_data_in    = w_gnt_a ? bus.a_wdata : w_gnt_b ? bus.b_wdata : '0;
  assign bus.rf_write_ctrl = w_gnt_a ? bus.a_we    : w_gnt_b ? bus.b_we    : 1'b0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last       <= 1'b1;
      r_lock_valid <= 1'b0;
      r_lock_owner <= 1'b0;
      r_burst_cnt  <= '0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      r_a_rvalid <= w_gnt_a && !bus.a_we;
      r_b_rvalid <= w_gnt_b && !bus.b_we;
      if (w_gnt_a && !bus.a_we) r_a_rdata <= bus.rf_data_out;
      if (w_gnt_b && !bus.b_we) r_b_rdata <= bus.rf_data_out;
      if (w_any) r_last <= w_gnt_b;
      if (w_any && w_lock && r_lock_valid && r_lock_owner == w_gnt_b)
        r_burst_cnt <= r_burst_cnt + {3'b0, r_burst_cnt != 4'hf};
      else if (w_any && w_lock) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_gnt_b;
        r_burst_cnt  <= 4'd1;
      end else if (w_any || !w_owner_req) begin
        r_lock_valid <= 1'b0;
        r_burst_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: vector table plus read-return scoreboard for reg_file_arbiter.
module tb_reg_file_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_arbiter_if bus ();
  reg_file_arbiter #(.MAX_BURST(4)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  assign bus.rf_data_out = mem[bus.rf_reg_in];
  always @(posedge clk) if (bus.rf_write_ctrl) mem[bus.rf_reg_in] <= bus.rf_data_in;

  typedef struct {
    logic       rst;
    logic       ar, aw, al;
    logic [3:0] areg;
    logic [7:0] awd;
    logic       br, bw, bl;
    logic [3:0] breg;
    logic [7:0] bwd;
    logic       ga, gb;
  } vec_t;
  typedef struct {
    logic       port;
    logic [7:0] d;
  } rd_t;

  rd_t        q[$];
  vec_t       tbl[$];
  logic [7:0] held_a = 8'h00, held_b = 8'h00;
  int         n_chk = 0, n_pass = 0;

  function automatic vec_t mk(input logic rst_i, ar, aw, al, input logic [3:0] areg, input logic [7:0] awd,
                              input logic br, bw, bl, input logic [3:0] breg, input logic [7:0] bwd,
                              input logic ga, gb);
    vec_t v;
    v.rst = rst_i; v.ar = ar; v.aw = aw; v.al = al; v.areg = areg; v.awd = awd;
    v.br = br; v.bw = bw; v.bl = bl; v.breg = breg; v.bwd = bwd; v.ga = ga; v.gb = gb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input vec_t v);
    rd_t e;
    @(negedge clk);
    rst = v.rst;
    bus.a_req = v.ar; bus.a_we = v.aw; bus.a_lock = v.al; bus.a_reg = v.areg; bus.a_wdata = v.awd;
    bus.b_req = v.br; bus.b_we = v.bw; bus.b_lock = v.bl; bus.b_reg = v.breg; bus.b_wdata = v.bwd;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.port) held_b = e.d; else held_a = e.d;
      chk("a_rvalid", {7'b0, bus.a_rvalid}, {7'b0, !e.port});
      chk("b_rvalid", {7'b0, bus.b_rvalid}, {7'b0, e.port});
    end else begin
      chk("a_rvalid idle", {7'b0, bus.a_rvalid}, 8'd0);
      chk("b_rvalid idle", {7'b0, bus.b_rvalid}, 8'd0);
    end
    chk("a_rdata", bus.a_rdata, held_a);
    chk("b_rdata", bus.b_rdata, held_b);
    chk("a_gnt", {7'b0, bus.a_gnt}, {7'b0, v.ga});
    chk("b_gnt", {7'b0, bus.b_gnt}, {7'b0, v.gb});
    chk("rf_reg_in", {4'b0, bus.rf_reg_in}, {4'b0, v.ga ? v.areg : v.gb ? v.breg : 4'd0});
    chk("rf_data_in", bus.rf_data_in, v.ga ? v.awd : v.gb ? v.bwd : 8'd0);
    chk("rf_write_ctrl", {7'b0, bus.rf_write_ctrl}, {7'b0, v.ga ? v.aw : v.gb ? v.bw : 1'b0});
    if (v.ga) begin
      if (v.aw) ref_mem[v.areg] = v.awd;
      else q.push_back('{port: 1'b0, d: ref_mem[v.areg]});
    end
    if (v.gb) begin
      if (v.bw) ref_mem[v.breg] = v.bwd;
      else q.push_back('{port: 1'b1, d: ref_mem[v.breg]});
    end
    if (v.rst) begin
      held_a = 8'h00;
      held_b = 8'h00;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle, a_wr1, b_rd0, b_lk, a_w4, b_lk_rd3, a_w5;
    bus.a_req = 0; bus.a_we = 0; bus.a_lock = 0; bus.a_reg = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_lock = 0; bus.b_reg = 0; bus.b_wdata = 0;
    idle  = mk(0, 0,0,0, 4'd0, 8'd0,   0,0,0, 4'd0, 8'd0, 0,0);
    tbl.push_back(mk(1, 1,1,0, 4'd3, 8'd99, 0,0,0, 4'd0, 8'd0, 0,0));
    tbl.push_back(mk(1, 0,0,0, 4'd0, 8'd0,  0,0,0, 4'd0, 8'd0, 0,0));
    tbl.push_back(mk(0, 1,1,0, 4'd0, 8'd22, 0,0,0, 4'd0, 8'd0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 1,0,0, 4'd0, 8'd0,  0,0,0, 4'd0, 8'd0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(mk(1, 0,0,0, 4'd0, 8'd0,  0,0,0, 4'd0, 8'd0, 0,0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 1,1,0, 4'd1, 8'h11, 1,0,0, 4'd0, 8'd0, (i % 2) == 0, (i % 2) == 1));
    tbl.push_back(mk(0, 1,1,0, 4'd15, 8'd187, 0,0,0, 4'd0, 8'd0, 1,0));
    tbl.push_back(mk(0, 0,0,0, 4'd0, 8'd0,  1,0,0, 4'd15, 8'd0, 0,1));
    for (int i = 0; i < 6; i++) tbl.push_back(idle);
    tbl.push_back(mk(0, 0,0,0, 4'd0, 8'd0,  1,1,0, 4'd2, 8'h5a, 0,1));
    foreach (tbl[i]) step(tbl[i]);

    b_lk     = mk(0, 0,0,0, 4'd0, 8'd0,   1,0,1, 4'd2, 8'd0, 0,1);
    a_w4     = mk(0, 1,1,0, 4'd4, 8'h44,  1,0,1, 4'd2, 8'd0, 0,1);
    step(b_lk);
    for (int i = 0; i < 3; i++) step(a_w4);
    a_w4.ga = 1; a_w4.gb = 0;
    step(a_w4);
    @(posedge clk); #1;
    chk("burst_cnt after yield", {4'b0, dut.r_burst_cnt}, 8'd0);
    chk("lock_valid after yield", {7'b0, dut.r_lock_valid}, 8'd0);
    for (int i = 0; i < 3; i++) step(b_lk);

    b_lk_rd3 = mk(0, 1,1,0, 4'd5, 8'h55, 1,0,1, 4'd3, 8'd0, 0,1);
    step(b_lk_rd3);
    a_w5 = b_lk_rd3; a_w5.rst = 1; a_w5.gb = 0;
    step(a_w5);
    @(posedge clk); #1;
    chk("lock_valid after reset", {7'b0, dut.r_lock_valid}, 8'd0);
    chk("burst_cnt after reset", {4'b0, dut.r_burst_cnt}, 8'd0);
    a_w5.rst = 0; a_w5.ga = 1;
    step(a_w5);
    step(b_lk);
    step(idle);
    step(idle);
    step(idle);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Shares the single-port 16x8 register file between two requesters: port A, the execute stage, and port B, the loader/debug port. Each cycle it grants at most one access, steers that requester's register index, write data and write strobe onto the register file, and returns registered read data. Round-robin fairness applies by default. A bounded lock lets a requester hold the port for a short burst of back-to-back accesses.

## Interface
- MAX_BURST, default 4: maximum consecutive locked grants to one requester while the other waits. Legal range 1..15.

- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- a_req  in  1  port A access request; held until granted
- a_we  in  1  port A: 1 = write, 0 = read
- a_lock  in  1  port A requests to keep the grant after this access
- a_reg  in  4  port A register index
- a_wdata  in  8  port A write data
- a_gnt  out  1  port A access performed this cycle
- a_rdata  out  8  port A read data, registered
- a_rvalid  out  1  a_rdata updated this cycle (1-cycle pulse)
- b_req, b_we, b_lock, b_reg, b_wdata, b_gnt, b_rdata, b_rvalid: same as port A, for port B
- rf_reg_in  out  4  to register file reg_in
- rf_data_in  out  8  to register file data_in
- rf_write_ctrl  out  1  to register file write_ctrl
- rf_data_out  in  8  from register file data_out (combinational read)

## Operation
- Registered state:
  - last: last granted port, 0=A, 1=B.
  - lock_valid and lock_owner.
  - burst_cnt: 4 bits.
  - a_rdata, a_rvalid, b_rdata, b_rvalid.
- Grant decision is combinational from current requests and registered state, evaluated in this priority order:
  1. If lock_valid, the owner requests, and either the other port is idle or burst_cnt < MAX_BURST: grant the owner.
  2. Else if only one port requests: grant it.
  3. Else if both request: grant the port != last. On a forced yield after a full burst, this is the non-owner.
  4. Else: no grant.
- When a port is granted:
  - rf_reg_in = x_reg.
  - rf_data_in = x_wdata.
  - rf_write_ctrl = x_we.
  - Exactly one of a_gnt or b_gnt is high.
- When no port is granted: rf_reg_in = 0, rf_data_in = 0, rf_write_ctrl = 0.
- Granted read: at the posedge, x_rdata <= rf_data_out and x_rvalid <= 1. Otherwise x_rvalid <= 0. x_rdata holds its value between reads.
- Granted write: the register file commits it at the same posedge. No rvalid pulse.
- On any grant to port X, last <= X.
- Lock update, applied on a grant to X:
  - x_lock=1 and X already the lock owner: burst_cnt saturates-increments.
  - x_lock=1 and X not the owner: lock_valid <= 1, lock_owner <= X, burst_cnt <= 1.
  - x_lock=0: lock_valid <= 0, burst_cnt <= 0.
- Lock release also happens when:
  - the owner has req=0 in a cycle, or
  - the non-owner is granted (forced yield).
  - In both cases: lock_valid <= 0, burst_cnt <= 0.
- A forced yield does not carry the lock to the yielding-to port unless its own x_lock=1.

## Timing
- Reset values:
  - a_gnt = b_gnt = 0 (while RESET is high).
  - a_rvalid = b_rvalid = 0.
  - a_rdata = b_rdata = 0.
  - rf outputs idle (0).
  - last = 1, so A wins the first tie.
  - lock_valid = 0, burst_cnt = 0.
- During RESET, all grants and rf_write_ctrl are forced to 0, so no register-file write can occur.
- Reset mid-burst drops the lock and any pending rvalid at the next posedge.
- Grant latency: 0 cycles. gnt is high in the same cycle as req if the port wins.
- Read latency: 1 cycle. rdata and rvalid appear in the cycle after gnt.
- A write and a read of the same register by the two ports are never granted in the same cycle.
- A read granted in the cycle right after a write to that register returns the new value.
- A read in the write's own cycle is impossible by construction.
- Requester rule: the request must stay stable (req, we, reg, wdata, lock) until the cycle gnt=1. Back-to-back grants to the same port are allowed every cycle.
- With both ports continuously requesting and no locks, grants alternate A, B, A, B, ...
- With continuous locks on both ports, the worst-case wait for either port is MAX_BURST cycles.

## Test plan
- Reset, then A writes r0=22 while B idle → a_gnt=1 that cycle, rf_write_ctrl=1, rf_reg_in=0. A later A read of r0 gives a_rdata=22 and a_rvalid=1 one cycle after the read's gnt.
- Both ports request unlocked continuously for 6 cycles from reset → grant order A,B,A,B,A,B. The rf_reg_in sequence matches the granted port's index each cycle.
- B requests with b_lock=1 for 8 cycles, A requests continuously from the second cycle, MAX_BURST=4 → B granted 4 consecutive times, then A is granted. burst_cnt returns to 0.
- A writes r15=187, then B reads r15 in the next cycle → b_rdata=187, b_rvalid pulses for exactly one cycle.
- RESET asserted during a locked B burst with A waiting → next cycle: gnt=0, rvalid=0, lock cleared. After RESET drops with both requesting, A is granted first.
- Read granted in cycle N with no further reads → rvalid high only in cycle N+1. rdata still holds the value at N+5.
